// File: rtl/reg_access_ctrl.sv
// -----------------------------------------------------------------------------
// reg_access_ctrl
// Host-side access controller for a 32 x 32-bit register file. It accepts one
// request at a time (read, write, dump of x0..x31, or reserved). It drives the
// register-file ports and returns one response per register touched, using a
// valid/ready handshake.
//
// Optional feature: define REGACC_READBACK_EN to add a CHECK state after every
// non-x0 write. CHECK reads the register back and flags rsp_err on a mismatch.
// This adds one cycle of write latency.
//
// Ports
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   req_valid      in   host request valid
//   req_ready      out  high only in IDLE, from the first edge after reset
//   req_op[1:0]    in   00 read, 01 write, 10 dump, 11 reserved
//   req_addr[4:0]  in   target register index
//   req_wdata[31:0] in  write data
//   rsp_valid      out  response valid (RESP state)
//   rsp_ready      in   host accepts response
//   rsp_rdata[31:0] out read data (0 for write / reserved responses)
//   rsp_addr[4:0]  out  register index the response refers to
//   rsp_err        out  error flag
//   rsp_last       out  final response of the current request
//   rf_rs1[4:0]    out  register-file read index
//   rf_rd[4:0]     out  register-file write index
//   rf_write_data  out  register-file write data (32 bits)
//   rf_reg_write   out  register-file write enable (WRITE state only)
//   rf_read_data1  in   asynchronous read data for rf_rs1 (32 bits)
// -----------------------------------------------------------------------------
module reg_access_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_addr,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_write_data,
  output logic        rf_reg_write,
  input  logic [31:0] rf_read_data1
);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
`ifdef REGACC_READBACK_EN
    CHECK = 3'd3,
`endif
    RESP  = 3'd4
  } state_e;

  state_e      state, next_state;
  op_e         req_op_e, op_q;
  logic [4:0]  cur_addr;   // latched address; doubles as the dump index
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        ready_en;   // holds req_ready low until the first edge after reset
  logic        accept;
  logic        rsp_done;
  logic        dump_more;
  logic        last_c;

  assign req_op_e  = op_e'(req_op);
  assign accept    = req_valid && req_ready;
  assign rsp_done  = (state == RESP) && rsp_ready;
  // A dump stops after index 31 instead of wrapping into a second pass.
  assign dump_more = (op_q == OP_DUMP) && (cur_addr != 5'd31);
  assign last_c    = (op_q != OP_DUMP) || (cur_addr == 5'd31);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every flop uses non-blocking assignment so all registers sample pre-edge values.
    if (!reset_n) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= next_state;
      ready_en <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (req_op_e)
            OP_READ, OP_DUMP: next_state = READ;
            OP_WRITE:         next_state = (req_addr == 5'd0) ? RESP : WRITE;
            default:          next_state = RESP;
          endcase
        end
      end
      READ:  next_state = RESP;
`ifdef REGACC_READBACK_EN
      WRITE: next_state = CHECK;
      CHECK: next_state = RESP;
`else
      WRITE: next_state = RESP;
`endif
      RESP: begin
        if (rsp_ready) next_state = dump_more ? READ : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_addr      = '0;
    rsp_err       = 1'b0;
    rsp_last      = 1'b0;
    rf_rs1        = '0;
    rf_rd         = '0;
    rf_write_data = '0;
    rf_reg_write  = 1'b0;
    unique case (state)
      IDLE:  req_ready = ready_en;
      READ:  rf_rs1    = cur_addr;
      WRITE: begin
        rf_reg_write  = 1'b1;
        rf_rd         = cur_addr;
        rf_write_data = wdata_q;
      end
`ifdef REGACC_READBACK_EN
      CHECK: rf_rs1 = cur_addr;
`endif
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_addr  = cur_addr;
        rsp_err   = err_q;
        rsp_last  = last_c;
      end
      default: ;
    endcase
  end

  // Request latch, read capture, readback compare and dump index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_READ;
      cur_addr <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= req_op_e;
        cur_addr <= (req_op_e == OP_DUMP) ? 5'd0 : req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
        err_q    <= (req_op_e == OP_RSVD) ||
                    ((req_op_e == OP_WRITE) && (req_addr == 5'd0));
      end
      if (state == READ) rdata_q <= rf_read_data1;
`ifdef REGACC_READBACK_EN
      if (state == CHECK) err_q <= (rf_read_data1 != wdata_q);
`endif
      if (rsp_done && dump_more) cur_addr <= cur_addr + 5'd1;
    end
  end

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, system clock, all state updates on rising edge.
REQ-002 SHALL have: reset_n input 1, asynchronous active-low reset.
REQ-003 SHALL have: req_valid input 1, host request valid.
REQ-004 SHALL have: req_ready output 1, block can accept a request.
REQ-005 SHALL have: req_op input 2, request type: 00 read, 01 write, 10 dump (read x0..x31), 11 reserved.
REQ-006 SHALL have: req_addr input 5, target register index.
REQ-007 SHALL have: req_wdata input 32, write data.
REQ-008 SHALL have: rsp_valid output 1, response valid.
REQ-009 SHALL have: rsp_ready input 1, host accepts response.
REQ-010 SHALL have: rsp_rdata output 32, read data, 0 for write responses.
REQ-011 SHALL have: rsp_addr output 5, register index the response refers to.
REQ-012 SHALL have: rsp_err output 1, error flag.
REQ-013 SHALL have: rsp_last output 1, final response of a request.
REQ-014 SHALL have: rf_rs1 output 5, rf_rd output 5, rf_write_data output 32, rf_reg_write output 1, all to the register file.
REQ-015 SHALL have: rf_read_data1 input 32, asynchronous read data from the register file for rf_rs1.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE, CHECK, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-018 SHALL latch req_op, req_addr and req_wdata on acceptance; inputs changing afterwards have no effect.
REQ-019 Read: IDLE->READ; in READ, rf_rs1=latched addr; rf_read_data1 captured at the end of READ; READ->RESP; rsp_valid first high 2 cycles after the accepting edge.
REQ-020 Write, addr!=0: IDLE->WRITE; rf_reg_write=1 for exactly one cycle with rf_rd=addr and rf_write_data=wdata; WRITE->CHECK or RESP per REQ-031/032.
REQ-021 Write, addr=0: rf_reg_write SHALL stay 0; go straight to RESP with rsp_err=1.
REQ-022 Dump: 5-bit index counter starts at 0; READ/RESP pairs for each index; rsp_addr=index; rsp_last=1 only on index 31; after index 31, return to IDLE; the counter SHALL NOT wrap into a second pass.
REQ-023 Reserved op SHALL give one RESP with rsp_err=1, rsp_rdata=0, rsp_last=1, with no register-file access.
REQ-024 In RESP, rsp_valid=1 and all rsp_* outputs SHALL hold stable until rsp_ready=1 is sampled; the handshake edge leaves RESP.
REQ-025 rsp_last SHALL be 1 for every read, write and reserved response.
REQ-026 rf_reg_write SHALL be 0 in every state except WRITE.
REQ-027 rf_rs1, rf_rd and rf_write_data SHALL be 0 in IDLE.
REQ-028 rsp_rdata SHALL be 0 for write responses.

Reset
REQ-029 reset_n=0 SHALL force IDLE immediately, in any state including mid-dump or mid-write, without waiting for a clock edge.
REQ-030 While reset is asserted, all outputs SHALL be 0 except req_ready; req_ready SHALL be 0 during reset and 1 from the first edge after reset_n rises.

Configuration
REQ-031 With REGACC_READBACK_EN defined, a non-x0 write SHALL pass WRITE->CHECK; CHECK drives rf_rs1=addr and compares rf_read_data1 with wdata; a mismatch sets rsp_err=1; then CHECK->RESP, so rsp_valid is high 3 cycles after acceptance.
REQ-032 Without REGACC_READBACK_EN, CHECK SHALL be absent: WRITE->RESP, rsp_valid is high 2 cycles after acceptance, and rsp_err=0 for non-x0 writes.

Verification
REQ-033 Reset then idle: rsp_valid=0, rf_reg_write=0; req_ready=1 after reset_n rises.
REQ-034 Write 123 to x5, then read x5 with rsp_ready=1: exactly one rf_reg_write pulse; read rsp_rdata=123, rsp_addr=5, rsp_err=0.
REQ-035 Write 999 to x0: no rf_reg_write pulse; rsp_err=1; a later read of x0 returns 0.
REQ-036 Write x3=50, x10=75, then dump with rsp_ready toggling every other cycle: 32 responses; index 3 = 50, index 10 = 75, index 0 = 0; rsp_last only on index 31; outputs stable while stalled.
REQ-037 reset_n pulsed low during the dump at index 7: rsp_valid drops immediately; after release, state is IDLE and the next read works.
REQ-038 With REGACC_READBACK_EN defined and the RF model corrupting the write: rsp_err=1 at 3-cycle latency; without the macro: rsp_err=0 at 2-cycle latency.
